// File: rtl/pe_acc_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pe_acc_buffer
// Purpose  : Partial-sum accumulator buffer below the PE array. Accumulates
//            the 16 column outputs into an on-chip word memory using a
//            2-stage read-modify-write pipeline with forwarding, and streams
//            stored sums out over a valid/ready handshake on request.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            acc_enable        - accumulate strobe (one word per cycle)
//            acc_clear         - with acc_enable: overwrite instead of add
//            acc_addr          - target word address
//            pe_acc_out        - lane data, lane i at [i*ACC_W +: ACC_W]
//            rd_start          - pulse: start readout of rd_count words
//            rd_count          - word count from address 0 (0 means DEPTH)
//            rd_busy, rd_done  - readout in progress / completion pulse
//            out_valid, out_ready, out_data, out_addr - readout stream
//            acc_err           - sticky error flag
// Revision : 1.0 - initial release
// ============================================================================
module pe_acc_buffer #(
  parameter int ARRAY_DIM = 16,
  parameter int ACC_W     = 32,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         acc_enable,
  input  logic                         acc_clear,
  input  logic [ADDR_W-1:0]            acc_addr,
  input  logic [ARRAY_DIM*ACC_W-1:0]   pe_acc_out,
  input  logic                         rd_start,
  input  logic [ADDR_W:0]              rd_count,
  output logic                         rd_busy,
  output logic                         rd_done,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ARRAY_DIM*ACC_W-1:0]   out_data,
  output logic [ADDR_W-1:0]            out_addr,
  output logic                         acc_err
);

  localparam int              WORD_W  = ARRAY_DIM * ACC_W;
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_RUN   = 2'd1,
    R_DRAIN = 2'd2
  } rd_state_t;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [WORD_W-1:0] mem [DEPTH];

  // --------------------------------------------------------------------------
  // Accumulate pipeline state
  // --------------------------------------------------------------------------
  logic                s1_valid;
  logic                s1_clear;
  logic [ADDR_W-1:0]   s1_addr;
  logic [WORD_W-1:0]   s1_data;
  logic [WORD_W-1:0]   mem_rd;      // memory word read for the S1 entry
  logic                s2_valid;
  logic [ADDR_W-1:0]   s2_addr;
  logic [WORD_W-1:0]   s2_word;     // value written at the previous edge

  logic                acc_in_range;
  logic                acc_go;
  logic [WORD_W-1:0]   acc_base;
  logic [WORD_W-1:0]   new_word;

  // --------------------------------------------------------------------------
  // Readout state
  // --------------------------------------------------------------------------
  rd_state_t           state;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W-1:0]   rd_last;
  logic [ADDR_W:0]     count_eff;
  logic [ADDR_W:0]     last_addr;
  logic [WORD_W-1:0]   q_data [2];
  logic [ADDR_W-1:0]   q_addr [2];
  logic [1:0]          q_cnt;
  logic                q_head;
  logic                q_tail;
  logic                issue;
  logic                pop;
  logic [ADDR_W-1:0]   port_addr;

  assign acc_in_range = ({1'b0, acc_addr} < DEPTH_C);
  assign acc_go       = acc_enable & acc_in_range;

  // The single memory read port belongs to the accumulate path whenever a
  // strobe is present; the readout only gets it on otherwise idle cycles.
  assign port_addr = acc_enable ? acc_addr : rd_ptr;

  // A readout read must not overtake a pending write, so it waits until the
  // accumulate pipeline holds nothing that is still to be written.
  assign issue = (state == R_RUN) && (q_cnt != 2'd2) && !acc_enable && !s1_valid;
  assign pop   = out_valid & out_ready;

  // The read issued one edge ago could not see the write committed on that
  // same edge; take that write's value directly when the addresses match.
  assign acc_base = (s2_valid && (s2_addr == s1_addr)) ? s2_word : mem_rd;

  for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_lane
    assign new_word[i*ACC_W +: ACC_W] = s1_clear ? s1_data[i*ACC_W +: ACC_W]
                                      : acc_base[i*ACC_W +: ACC_W] + s1_data[i*ACC_W +: ACC_W];
  end

  // --------------------------------------------------------------------------
  // Memory array: one write port (S2 commit) and one read port whose result
  // is captured either for the accumulate pipeline or into the output queue.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (s1_valid) begin
      mem[s1_addr] <= new_word;
    end
    if (acc_enable) begin
      mem_rd <= mem[port_addr];
    end
    if (issue) begin
      q_data[q_tail] <= mem[port_addr];
    end
  end

  // --------------------------------------------------------------------------
  // Accumulate pipeline valids
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= acc_go;
      s2_valid <= s1_valid;
    end
  end

  // Datapath registers carry no reset; they are qualified by the valids.
  always_ff @(posedge clk) begin
    if (acc_go) begin
      s1_clear <= acc_clear;
      s1_addr  <= acc_addr;
      s1_data  <= pe_acc_out;
    end
    if (s1_valid) begin
      s2_addr <= s1_addr;
      s2_word <= new_word;
    end
  end

  // --------------------------------------------------------------------------
  // Readout length: zero (or anything beyond the buffer) means whole buffer
  // --------------------------------------------------------------------------
  always_comb begin
    count_eff = rd_count;
    if ((rd_count == '0) || (rd_count > DEPTH_C)) begin
      count_eff = DEPTH_C;
    end
  end

  assign last_addr = count_eff - 1'b1;

  // --------------------------------------------------------------------------
  // Readout FSM, output queue bookkeeping and error flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= R_IDLE;
      rd_busy   <= 1'b0;
      rd_done   <= 1'b0;
      rd_ptr    <= '0;
      rd_last   <= '0;
      q_cnt     <= 2'd0;
      q_head    <= 1'b0;
      q_tail    <= 1'b0;
      q_addr[0] <= '0;
      q_addr[1] <= '0;
      acc_err   <= 1'b0;
    end else begin
      rd_done <= 1'b0;

      if ((acc_enable && !acc_in_range) || (rd_start && rd_busy)) begin
        acc_err <= 1'b1;
      end

      // Queue slot is reserved at issue; the word lands there on this edge.
      if (issue) begin
        q_addr[q_tail] <= rd_ptr;
        q_tail         <= ~q_tail;
      end
      if (pop) begin
        q_head <= ~q_head;
      end
      case ({issue, pop})
        2'b10:   q_cnt <= q_cnt + 2'd1;
        2'b01:   q_cnt <= q_cnt - 2'd1;
        default: q_cnt <= q_cnt;
      endcase

      case (state)
        R_IDLE: begin
          if (rd_start) begin
            rd_ptr  <= '0;
            rd_last <= last_addr[ADDR_W-1:0];
            rd_busy <= 1'b1;
            state   <= R_RUN;
          end
        end
        R_RUN: begin
          if (issue) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_ptr == rd_last) begin
              state <= R_DRAIN;
            end
          end
        end
        R_DRAIN: begin
          // Nothing is pushed in this state, so a pop with one entry left
          // is the acceptance of the final word.
          if (pop && (q_cnt == 2'd1)) begin
            rd_done <= 1'b1;
            rd_busy <= 1'b0;
            state   <= R_IDLE;
          end
        end
        default: begin
          state <= R_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output stream: head of the queue, zero while nothing is valid
  // --------------------------------------------------------------------------
  assign out_valid = (q_cnt != 2'd0);
  assign out_data  = out_valid ? q_data[q_head] : '0;
  assign out_addr  = out_valid ? q_addr[q_head] : '0;

endmodule
`default_nettype wire

// File: tb/tb_pe_acc_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pe_acc_buffer
// Purpose  : Self-checking bench for pe_acc_buffer. Accumulate operations
//            come from tables of {enable, clear, addr, lane pattern}; readout
//            results are checked against hand-computed expected lane patterns
//            (lane i = base + i*step, 32-bit wrap).
//            DEPTH is set to 1000 with ADDR_W=10 so out-of-range addresses
//            are representable on the acc_addr port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_acc_buffer;

  localparam int ARRAY_DIM = 16;
  localparam int ACC_W     = 32;
  localparam int DEPTH     = 1000;
  localparam int ADDR_W    = 10;
  localparam int W         = ARRAY_DIM * ACC_W;
  localparam int BUDGET    = 200;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              acc_enable = 1'b0;
  logic              acc_clear = 1'b0;
  logic [ADDR_W-1:0] acc_addr = '0;
  logic [W-1:0]      pe_acc_out = '0;
  logic              rd_start = 1'b0;
  logic [ADDR_W:0]   rd_count = '0;
  logic              rd_busy;
  logic              rd_done;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W-1:0]      out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              acc_err;

  always #5 clk = ~clk;

  pe_acc_buffer #(
    .ARRAY_DIM (ARRAY_DIM),
    .ACC_W     (ACC_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .acc_enable (acc_enable),
    .acc_clear  (acc_clear),
    .acc_addr   (acc_addr),
    .pe_acc_out (pe_acc_out),
    .rd_start   (rd_start),
    .rd_count   (rd_count),
    .rd_busy    (rd_busy),
    .rd_done    (rd_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .acc_err    (acc_err)
  );

  typedef struct {
    logic              en;
    logic              clr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       base;
    logic [31:0]       step;
  } op_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] step;
  } exp_t;

  op_t  ops[$];
  exp_t exp_tab[8];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mkword(input logic [31:0] base, input logic [31:0] step);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      w[i*ACC_W +: ACC_W] = base + step * 32'(i);
    end
    return w;
  endfunction

  function automatic void add_op(input logic en, input logic clr, input logic [ADDR_W-1:0] addr,
                                 input logic [31:0] base, input logic [31:0] step);
    ops.push_back('{en, clr, addr, base, step});
  endfunction

  function automatic void set_exp(input int a, input logic [31:0] base, input logic [31:0] step);
    exp_tab[a] = '{base, step};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply the queued accumulate table one entry per cycle, then idle.
  task automatic run_ops();
    for (int j = 0; j < ops.size(); j++) begin
      tick();
      acc_enable = ops[j].en;
      acc_clear  = ops[j].clr;
      acc_addr   = ops[j].addr;
      pe_acc_out = mkword(ops[j].base, ops[j].step);
    end
    tick();
    acc_enable = 1'b0;
    acc_clear  = 1'b0;
    tick();
    tick();
    ops.delete();
  endtask

  // Read cnt words from address 0 and check them against exp_tab.
  task automatic readout(input int cnt, input bit toggle, input bit contend, input bit dup);
    int               idx        = 0;
    int               done_cnt   = 0;
    int               done_k     = 0;
    bit               prev_stall = 1'b0;
    bit               prev_last  = 1'b0;
    logic [W-1:0]     pd         = '0;
    logic [ADDR_W-1:0] pa        = '0;
    tick();
    rd_start  = 1'b1;
    rd_count  = cnt[ADDR_W:0];
    out_ready = 1'b1;
    for (int k = 1; (k <= BUDGET) && (done_k == 0); k++) begin
      tick();
      rd_start = dup && (k == 1);
      if (dup && (k == 1)) rd_count = 11'd8;
      acc_enable = contend && ((k == 1) || (k == 2));
      acc_clear  = 1'b0;
      acc_addr   = (k == 1) ? 10'd6 : 10'd7;
      pe_acc_out = mkword(32'd1, 32'd0);
      out_ready  = toggle ? k[0] : 1'b1;

      if (prev_stall) begin
        chk("stall out_valid held", out_valid, 1);
        chk("stall out_data held", out_data, pd);
        chk("stall out_addr held", out_addr, pa);
      end
      if (prev_last) begin
        chk("rd_done after last", rd_done, 1);
        chk("rd_busy falls with rd_done", rd_busy, 0);
      end
      if (rd_done) begin
        done_cnt++;
        done_k = k;
      end
      if (!contend && (k == 1)) begin
        chk("latency out_valid low T+1", out_valid, 0);
        chk("rd_busy high", rd_busy, 1);
      end
      if (!contend && (k == 2)) begin
        chk("latency out_valid high T+2", out_valid, 1);
      end

      prev_stall = out_valid && !out_ready;
      pd         = out_data;
      pa         = out_addr;
      prev_last  = 1'b0;
      if (out_valid && out_ready && (done_k == 0)) begin
        if (idx < cnt) begin
          chk($sformatf("word %0d addr", idx), out_addr, idx);
          chk($sformatf("word %0d data", idx), out_data,
              mkword(exp_tab[idx].base, exp_tab[idx].step));
          if (idx == cnt - 1) begin
            prev_last = 1'b1;
            chk("rd_busy at last accept", rd_busy, 1);
          end
        end else begin
          chk("extra word emitted", 1, 0);
        end
        idx++;
      end
    end
    acc_enable = 1'b0;
    rd_start   = 1'b0;
    chk("rd_done seen within budget", done_k != 0, 1);
    chk("word count", idx, cnt);
    if (!toggle && !contend && !dup) begin
      chk("rd_done cycle at full rate", done_k, cnt + 2);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rd_done) done_cnt++;
    end
    chk("rd_done exactly once", done_cnt, 1);
    chk("idle out_valid", out_valid, 0);
    chk("idle rd_busy", rd_busy, 0);
  endtask

  initial begin
    int done_seen;
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("reset rd_busy", rd_busy, 0);
    chk("reset rd_done", rd_done, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_addr", out_addr, 0);
    chk("reset acc_err", acc_err, 0);
    rst_n = 1'b1;
    tick();

    // Phase 1: initialise 0..7, clear+gapped adds on 5, forwarding burst on 7
    add_op(1, 1, 10'd0, 32'd0,          32'd3);
    add_op(1, 1, 10'd1, 32'd0,          32'd0);
    add_op(1, 1, 10'd2, 32'h7FFF_FFFF,  32'd0);
    add_op(1, 1, 10'd3, 32'hFFFF_FFFF,  32'd0);
    add_op(1, 1, 10'd4, 32'd100,        32'd1);
    add_op(1, 1, 10'd6, 32'hA000_0000,  32'd1);
    add_op(1, 1, 10'd5, 32'd1,          32'd1);
    add_op(0, 0, 10'd0, 32'd0,          32'd0);
    add_op(1, 0, 10'd5, 32'd10,         32'd0);
    add_op(0, 0, 10'd0, 32'd0,          32'd0);
    add_op(0, 0, 10'd0, 32'd0,          32'd0);
    add_op(1, 0, 10'd5, 32'd10,         32'd0);
    add_op(0, 1, 10'd5, 32'd999,        32'd0);   // clear without enable: ignored
    add_op(1, 0, 10'd5, 32'd10,         32'd0);
    add_op(0, 0, 10'd0, 32'd0,          32'd0);
    add_op(1, 1, 10'd7, 32'd0,          32'd0);
    add_op(1, 0, 10'd7, 32'd1,          32'd0);
    add_op(1, 0, 10'd7, 32'd2,          32'd0);
    add_op(1, 0, 10'd7, 32'd3,          32'd0);
    run_ops();
    set_exp(0, 32'd0,         32'd3);
    set_exp(1, 32'd0,         32'd0);
    set_exp(2, 32'h7FFF_FFFF, 32'd0);
    set_exp(3, 32'hFFFF_FFFF, 32'd0);
    set_exp(4, 32'd100,       32'd1);
    set_exp(5, 32'd31,        32'd1);
    set_exp(6, 32'hA000_0000, 32'd1);
    set_exp(7, 32'd6,         32'd0);
    readout(8, 1'b0, 1'b0, 1'b0);

    // Phase 2: wrap-around adds and interleaved back-to-back 1,7,1,7
    add_op(1, 0, 10'd2, 32'd1,  32'd0);
    add_op(1, 0, 10'd3, 32'd1,  32'd0);
    add_op(1, 0, 10'd1, 32'd5,  32'd0);
    add_op(1, 0, 10'd7, 32'd10, 32'd0);
    add_op(1, 0, 10'd1, 32'd5,  32'd0);
    add_op(1, 0, 10'd7, 32'd10, 32'd0);
    run_ops();
    set_exp(1, 32'd10,        32'd0);
    set_exp(2, 32'h8000_0000, 32'd0);
    set_exp(3, 32'd0,         32'd0);
    set_exp(7, 32'd26,        32'd0);
    readout(8, 1'b1, 1'b0, 1'b0);

    // Contention: +1 strobes to 6 and 7 while the readout is running
    set_exp(6, 32'hA000_0001, 32'd1);
    set_exp(7, 32'd27,        32'd0);
    readout(8, 1'b0, 1'b1, 1'b0);
    chk("acc_err clean after contention", acc_err, 0);

    // Out-of-range strobes: flag error, leave stored words untouched
    add_op(1, 1, 10'd1000, 32'h55, 32'd0);
    add_op(1, 0, 10'd1023, 32'h55, 32'd0);
    run_ops();
    chk("acc_err on addr >= DEPTH", acc_err, 1);
    readout(8, 1'b0, 1'b0, 1'b0);

    // Reset clears the sticky flag; rd_start while busy sets it again
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("acc_err cleared by reset", acc_err, 0);
    add_op(1, 1, 10'd0, 32'd7,          32'd1);
    add_op(1, 1, 10'd1, 32'h100,        32'h10);
    add_op(1, 1, 10'd2, 32'hDEAD_BEEF,  32'd0);
    add_op(1, 1, 10'd3, 32'd0,          32'hFFFF_FFFF);
    run_ops();
    set_exp(0, 32'd7,         32'd1);
    set_exp(1, 32'h100,       32'h10);
    set_exp(2, 32'hDEAD_BEEF, 32'd0);
    set_exp(3, 32'd0,         32'hFFFF_FFFF);
    readout(4, 1'b0, 1'b0, 1'b1);
    chk("acc_err on rd_start while busy", acc_err, 1);

    // Reset in the middle of a stalled readout
    tick();
    rd_start  = 1'b1;
    rd_count  = 11'd8;
    out_ready = 1'b0;
    tick();
    rd_start = 1'b0;
    tick();
    tick();
    chk("mid-readout out_valid before reset", out_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset rd_busy", rd_busy, 0);
    chk("async reset out_data", out_data, 0);
    chk("async reset acc_err", acc_err, 0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (rd_done) done_seen++;
    end
    chk("no rd_done after abandoned readout", done_seen, 0);
    chk("no out_valid after abandoned readout", out_valid, 0);
    chk("rd_busy stays low after reset", rd_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
